// File: rtl/reg_file_sb_pkg.sv
// Shared widths, types and hazard helper for the scoreboarded register file.
package reg_file_sb_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int DATA_BUS     = 32;
    localparam int REG_COUNT    = 1 << REG_ADDR_BUS;

    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
    typedef logic [DATA_BUS-1:0]     data_t;
    typedef logic [1:0]              pend_cnt_t;

    localparam reg_addr_t REG_31   = reg_addr_t'(REG_COUNT - 1);
    localparam pend_cnt_t PEND_MAX = '1;

    // A read must wait unless the only outstanding write lands this very cycle.
    function automatic logic read_hazard(input pend_cnt_t cnt, input logic wb_hit);
        return (cnt >= pend_cnt_t'(2)) || ((cnt == pend_cnt_t'(1)) && !wb_hit);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and the RAW / scoreboard-full stall decision.
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      id_valid,
    input  logic      read_en_1,
    input  reg_addr_t read_addr_1,
    input  logic      read_en_2,
    input  reg_addr_t read_addr_2,
    input  logic      issue_en,
    input  reg_addr_t issue_addr,
    input  logic      wb_en,
    input  reg_addr_t wb_addr,
    output logic      stall_req
);

    pend_cnt_t cnt_q [REG_COUNT];
    pend_cnt_t cnt_d [REG_COUNT];

    logic haz_1;
    logic haz_2;
    logic full;
    logic accept;

    always_comb begin
        haz_1 = id_valid && read_en_1 && (read_addr_1 != '0) &&
                read_hazard(cnt_q[read_addr_1], wb_en && (wb_addr == read_addr_1));
        haz_2 = id_valid && read_en_2 && (read_addr_2 != '0) &&
                read_hazard(cnt_q[read_addr_2], wb_en && (wb_addr == read_addr_2));
        full  = id_valid && issue_en && (cnt_q[issue_addr] == PEND_MAX) &&
                !(wb_en && (wb_addr == issue_addr));
        stall_req = !rst && (haz_1 || haz_2 || full);
        accept    = id_valid && issue_en && !stall_req && (issue_addr != '0);
    end

    // A writeback to an idle counter is stale (e.g. in flight across a reset) and is not counted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        for (int r = 1; r <= int'(REG_31); r++) begin
            if ((accept && (issue_addr == reg_addr_t'(r))) &&
                !(wb_en && (wb_addr == reg_addr_t'(r)) && (cnt_q[r] != '0))) begin
                cnt_d[r] = cnt_q[r] + pend_cnt_t'(1);
            end else if (!(accept && (issue_addr == reg_addr_t'(r))) &&
                         (wb_en && (wb_addr == reg_addr_t'(r)) && (cnt_q[r] != '0))) begin
                cnt_d[r] = cnt_q[r] - pend_cnt_t'(1);
            end
        end
        cnt_d[0] = '0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// 32x32 register file with write-through bypass and a pending-write scoreboard.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_en_1,
    input  logic [REG_ADDR_BUS-1:0] read_addr_1,
    input  logic                    read_en_2,
    input  logic [REG_ADDR_BUS-1:0] read_addr_2,
    output logic [DATA_BUS-1:0]     read_data_1,
    output logic [DATA_BUS-1:0]     read_data_2,
    input  logic                    issue_en,
    input  logic [REG_ADDR_BUS-1:0] issue_addr,
    input  logic                    id_valid,
    input  logic                    wb_en,
    input  logic [REG_ADDR_BUS-1:0] wb_addr,
    input  logic [DATA_BUS-1:0]     wb_data,
    output logic                    stall_req
);

    data_t regs_q [REG_COUNT];

    function automatic data_t read_port(input logic en, input reg_addr_t addr, input data_t stored,
                                        input logic gate, input logic wbe, input reg_addr_t wba,
                                        input data_t wbd);
        if (gate || !en || (addr == '0)) return '0;
        if (wbe && (wba == addr))        return wbd;
        return stored;
    endfunction

    // Reset and bubbles both present zero operands; reset also suppresses the bypass.
    always_comb begin
        read_data_1 = read_port(read_en_1, read_addr_1, regs_q[read_addr_1],
                                rst || !id_valid, wb_en, wb_addr, wb_data);
        read_data_2 = read_port(read_en_2, read_addr_2, regs_q[read_addr_2],
                                rst || !id_valid, wb_en, wb_addr, wb_data);
    end

    // NOTE: the storage array is reset explicitly because reset must make every register read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .stall_req   (stall_req)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: the driver queues expected responses, a negedge monitor pops and compares.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    typedef struct {
        logic      rst;
        logic      id_valid;
        logic      re1;
        reg_addr_t ra1;
        logic      re2;
        reg_addr_t ra2;
        logic      ie;
        reg_addr_t ia;
        logic      wbe;
        reg_addr_t wba;
        data_t     wbd;
    } stim_t;

    typedef struct {
        string name;
        logic  stall;
        data_t rd1;
        data_t rd2;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      read_en_1, read_en_2, issue_en, id_valid, wb_en;
    reg_addr_t read_addr_1, read_addr_2, issue_addr, wb_addr;
    data_t     read_data_1, read_data_2, wb_data;
    logic      stall_req;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .id_valid    (id_valid),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall_req   (stall_req)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".stall"}, {31'd0, stall_req}, {31'd0, e.stall});
            check({e.name, ".rd1"}, read_data_1, e.rd1);
            check({e.name, ".rd2"}, read_data_2, e.rd2);
        end
    end

    function automatic stim_t mk(input int r, input int v, input int e1, input int a1, input int e2,
                                 input int a2, input int ie_, input int ia_, input int we,
                                 input int wa, input int wd);
        stim_t s;
        s.rst = r[0];      s.id_valid = v[0];
        s.re1 = e1[0];     s.ra1 = reg_addr_t'(a1);
        s.re2 = e2[0];     s.ra2 = reg_addr_t'(a2);
        s.ie  = ie_[0];    s.ia  = reg_addr_t'(ia_);
        s.wbe = we[0];     s.wba = reg_addr_t'(wa);
        s.wbd = data_t'(wd);
        return s;
    endfunction

    task automatic step(input stim_t s, input logic e_stall, input data_t e1, input data_t e2,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = s.rst;          id_valid = s.id_valid;
        read_en_1 = s.re1;    read_addr_1 = s.ra1;
        read_en_2 = s.re2;    read_addr_2 = s.ra2;
        issue_en = s.ie;      issue_addr = s.ia;
        wb_en = s.wbe;        wb_addr = s.wba;   wb_data = s.wbd;
        e.name = name; e.stall = e_stall; e.rd1 = e1; e.rd2 = e2;
        exp_q.push_back(e);
    endtask

    initial begin
        int budget;
        rst = 1'b1; id_valid = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;
        issue_en = 1'b0; wb_en = 1'b0;
        read_addr_1 = '0; read_addr_2 = '0; issue_addr = '0; wb_addr = '0; wb_data = '0;

        //          rst v  re1 a1 re2 a2 ie ia we wa wd
        step(mk(1, 1, 1, 5, 1, 5, 0, 0, 0, 0, 0),           1'b0, 32'h0, 32'h0, "in_reset");
        step(mk(0, 1, 1, 5, 1, 5, 0, 0, 0, 0, 0),           1'b0, 32'h0, 32'h0, "reset_read5");
        step(mk(0, 1, 1, 7, 1, 7, 0, 0, 1, 7, 'hDEADBEEF),  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "bypass7");
        step(mk(0, 1, 1, 7, 1, 7, 0, 0, 0, 0, 0),           1'b0, 32'hDEADBEEF, 32'hDEADBEEF, "stored7");
        step(mk(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue3");
        step(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0),           1'b1, 32'h0, 32'h0, "raw3_stall");
        step(mk(0, 1, 1, 3, 0, 0, 0, 0, 1, 3, 'h11),        1'b0, 32'h11, 32'h0, "raw3_wb");
        step(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue4_a");
        step(mk(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue4_b");
        step(mk(0, 1, 1, 4, 0, 0, 0, 0, 1, 4, 'hA1),        1'b1, 32'hA1, 32'h0, "dbl4_first_wb");
        step(mk(0, 1, 1, 4, 0, 0, 0, 0, 1, 4, 'hA2),        1'b0, 32'hA2, 32'h0, "dbl4_second_wb");
        step(mk(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0),           1'b0, 32'hA2, 32'h0, "dbl4_stored");
        step(mk(0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 'h55),        1'b0, 32'h0, 32'h0, "r0_issue_wb");
        step(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0),           1'b0, 32'h0, 32'h0, "r0_read");
        step(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue9_1");
        step(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue9_2");
        step(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0),           1'b0, 32'h0, 32'h0, "issue9_3");
        step(mk(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0),           1'b1, 32'h0, 32'h0, "issue9_full");
        step(mk(0, 0, 1, 9, 0, 0, 1, 9, 0, 0, 0),           1'b0, 32'h0, 32'h0, "bubble");
        step(mk(0, 1, 0, 0, 0, 0, 1, 9, 1, 9, 'h99),        1'b0, 32'h0, 32'h0, "full9_wb_same");
        step(mk(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0),           1'b0, 32'h0, 32'h0, "mid_reset");
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 9, 'h77),        1'b0, 32'h0, 32'h0, "stale_wb9");
        step(mk(0, 1, 1, 9, 0, 0, 1, 9, 0, 0, 0),           1'b0, 32'h77, 32'h0, "read9_issue");
        step(mk(0, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0),           1'b1, 32'h0, 32'h77, "raw9_port2");
        step(mk(0, 1, 0, 0, 1, 9, 0, 0, 1, 9, 'h88),        1'b0, 32'h0, 32'h88, "raw9_port2_wb");
        step(mk(0, 1, 1, 9, 1, 7, 0, 0, 0, 0, 0),           1'b0, 32'h88, 32'h0, "post_reset_data");

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
